// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4-input selector between four requesters.
// Break-before-make: the select address only moves while the mux enable is inactive.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX   = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       en_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);
    localparam logic [3:0] GAP_C      = 4'(GAP_CYCLES);

    state_t     r_state;
    logic [1:0] r_last;
    logic [7:0] r_hold_cnt;
    logic [3:0] r_gap_cnt;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_en_n;
    logic       r_busy;

    state_t     w_nxt_state;
    logic [1:0] w_nxt_last;
    logic [7:0] w_nxt_hold_cnt;
    logic [3:0] w_nxt_gap_cnt;
    logic [3:0] w_nxt_gnt;
    logic [1:0] w_nxt_sel;
    logic       w_nxt_en_n;
    logic       w_nxt_busy;
    logic [1:0] w_winner;
    logic [3:0] w_sel_oh;
    logic [3:0] w_others;
    logic       w_req_sel;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Lowest rotation distance from the previous owner wins; previous owner ranks last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign w_winner  = rr_pick(req, r_last);
    assign w_sel_oh  = onehot4(r_sel);
    assign w_others  = req & ~w_sel_oh;
    assign w_req_sel = req[r_sel];

    // Next-state and next-output computation for the arbitration sequence.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_last     = r_last;
        w_nxt_hold_cnt = r_hold_cnt;
        w_nxt_gap_cnt  = r_gap_cnt;
        w_nxt_gnt      = r_gnt;
        w_nxt_sel      = r_sel;
        w_nxt_en_n     = r_en_n;
        w_nxt_busy     = r_busy;
        case (r_state)
            ST_IDLE: begin
                w_nxt_gnt  = 4'b0000;
                w_nxt_en_n = 1'b1;
                if (req != 4'b0000) begin
                    w_nxt_sel   = w_winner;
                    w_nxt_state = ST_SETUP;
                    w_nxt_busy  = 1'b1;
                end else begin
                    w_nxt_busy = 1'b0;
                end
            end
            ST_SETUP: begin
                if (w_req_sel) begin
                    w_nxt_gnt      = w_sel_oh;
                    w_nxt_en_n     = 1'b0;
                    w_nxt_hold_cnt = 8'd1;
                    w_nxt_state    = ST_GRANT;
                end else begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_busy  = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!w_req_sel || ((r_hold_cnt == HOLD_MAX_C) && (w_others != 4'b0000))) begin
                    w_nxt_gnt     = 4'b0000;
                    w_nxt_en_n    = 1'b1;
                    w_nxt_last    = r_sel;
                    w_nxt_gap_cnt = 4'd1;
                    w_nxt_state   = ST_GAP;
                end else if (r_hold_cnt != HOLD_MAX_C) begin
                    w_nxt_hold_cnt = r_hold_cnt + 8'd1;
                end else begin
                    w_nxt_hold_cnt = r_hold_cnt;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt >= GAP_C) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_busy  = 1'b0;
                end else begin
                    w_nxt_gap_cnt = r_gap_cnt + 4'd1;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_gnt   = 4'b0000;
                w_nxt_en_n  = 1'b1;
                w_nxt_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset disables the mux immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_last     <= 2'd3;
            r_hold_cnt <= 8'd0;
            r_gap_cnt  <= 4'd0;
            r_gnt      <= 4'b0000;
            r_sel      <= 2'b00;
            r_en_n     <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_last     <= w_nxt_last;
            r_hold_cnt <= w_nxt_hold_cnt;
            r_gap_cnt  <= w_nxt_gap_cnt;
            r_gnt      <= w_nxt_gnt;
            r_sel      <= w_nxt_sel;
            r_en_n     <= w_nxt_en_n;
            r_busy     <= w_nxt_busy;
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign en_n = r_en_n;
    assign busy = r_busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: per-cycle vector tables with hand-derived outputs,
// checked through an expected-value queue, plus invariant checks on every sample.
module tb_mux4_rr_arbiter;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       en_n;
        logic       busy;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       en_n;
    logic       busy;

    vec_t  vecs[$];
    vec_t  exp_q[$];
    int    n_cmp;
    int    n_bad;
    string scen;
    logic [1:0] prev_sel;
    logic       prev_en_n;

    mux4_rr_arbiter #(.HOLD_MAX(8), .GAP_CYCLES(1)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (req),
        .gnt    (gnt),
        .sel    (sel),
        .en_n   (en_n),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s/%s[%0d]: got %b, expected %b", scen, name, idx, act, expv);
        end
    endtask

    task automatic check_outputs(input int idx, input vec_t x);
        logic sel_ok;
        check("out{gnt,sel,en_n,busy}", idx, {gnt, sel, en_n, busy}, {x.gnt, x.sel, x.en_n, x.busy});
        check("gnt_onehot0", idx, {7'd0, ((gnt & (gnt - 4'd1)) == 4'd0)}, 8'd1);
        check("gnt_vs_en_n", idx, {7'd0, ((gnt != 4'd0) == (en_n == 1'b0))}, 8'd1);
        sel_ok = (sel == prev_sel) || (prev_en_n && en_n);
        check("sel_break_before_make", idx, {7'd0, sel_ok}, 8'd1);
        prev_sel  = sel;
        prev_en_n = en_n;
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                       input logic e, input logic b);
        vecs.push_back('{req: r, gnt: g, sel: s, en_n: e, busy: b});
    endtask

    task automatic run_vecs();
        vec_t v;
        vec_t x;
        for (int i = 0; i < vecs.size(); i++) begin
            v   = vecs[i];
            req = v.req;
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            x = exp_q.pop_front();
            check_outputs(i, x);
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        vec_t rv;
        rv  = '{req: 4'b0000, gnt: 4'b0000, sel: 2'b00, en_n: 1'b1, busy: 1'b0};
        req = 4'b0000;
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        prev_sel  = 2'b00;
        prev_en_n = 1'b1;
        check_outputs(-1, rv);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] s;
        logic [3:0] oh;
        vec_t rv;
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        req       = 4'b0000;
        prev_sel  = 2'b00;
        prev_en_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single requester, then an aborted SETUP with last=2 so last must stay 2.
        scen = "single";
        do_reset();
        add(4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1);
        repeat (5) add(4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
        add(4'b1000, 4'b0000, 2'd3, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0);
        add(4'b1001, 4'b0000, 2'd3, 1'b1, 1'b1);
        add(4'b1001, 4'b1000, 2'd3, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 2'd3, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0);
        run_vecs();

        // Everyone requesting: 8-cycle grants rotating 0,1,2,3,0 with 3 disabled cycles between.
        scen = "all_req";
        do_reset();
        for (int g = 0; g < 5; g++) begin
            s  = 2'(g % 4);
            oh = 4'b0001 << s;
            add(4'b1111, 4'b0000, s, 1'b1, 1'b1);
            repeat (8) add(4'b1111, oh, s, 1'b0, 1'b1);
            if (g < 4) begin
                add(4'b1111, 4'b0000, s, 1'b1, 1'b1);
                add(4'b1111, 4'b0000, s, 1'b1, 1'b0);
            end
        end
        run_vecs();

        // Sole owner past the hold limit, then a competitor forces an immediate release.
        scen = "sole_owner";
        do_reset();
        add(4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
        repeat (19) add(4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
        add(4'b0101, 4'b0000, 2'd0, 1'b1, 1'b1);
        add(4'b0101, 4'b0000, 2'd0, 1'b1, 1'b0);
        add(4'b0101, 4'b0000, 2'd2, 1'b1, 1'b1);
        add(4'b0101, 4'b0100, 2'd2, 1'b0, 1'b1);
        add(4'b0101, 4'b0100, 2'd2, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
        run_vecs();

        // Abort in SETUP straight from reset; requester 0 wins next.
        scen = "abort";
        do_reset();
        add(4'b1000, 4'b0000, 2'd3, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0);
        add(4'b1001, 4'b0000, 2'd0, 1'b1, 1'b1);
        add(4'b1001, 4'b0001, 2'd0, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        run_vecs();

        // Asynchronous reset in the middle of a grant.
        scen = "reset_mid_grant";
        do_reset();
        add(4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);
        add(4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
        add(4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1);
        run_vecs();
        req = 4'b0010;
        #2;
        reset_n = 1'b0;
        #1;
        rv = '{req: 4'b0010, gnt: 4'b0000, sel: 2'b00, en_n: 1'b1, busy: 1'b0};
        prev_sel  = 2'b00;
        prev_en_n = 1'b1;
        check_outputs(-2, rv);
        @(negedge clk);
        reset_n = 1'b1;
        add(4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1);
        add(4'b0010, 4'b0010, 2'd1, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 2'd1, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0);
        run_vecs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
